uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, idle clocks inserted after each packet (0 = none).
REQ-003 SHALL have parameter TIMEOUT, default 65535, max clocks a locked requester may stall mid-packet.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock.
REQ-005 SHALL have reset input 1, synchronous active-high reset.
REQ-006 SHALL have req_valid input NREQ, per-requester byte available.
REQ-007 SHALL have req_data input 8*NREQ, byte of requester i on bits [8i+7:8i].
REQ-008 SHALL have req_last input NREQ, current byte ends the packet.
REQ-009 SHALL have req_ready output NREQ, one-clock pulse when the byte is accepted.
REQ-010 SHALL have tx_start output 1, one-clock start pulse to the shared transmitter.
REQ-011 SHALL have tx_data output 8, byte for the transmitter, valid while tx_start=1.
REQ-012 SHALL have tx_busy input 1, transmitter busy, which rises the clock after tx_start.
REQ-013 SHALL have grant output NREQ, one-hot owner of the transmitter, all-zero when unowned.
REQ-014 SHALL have timeout_err output 1, one-clock pulse when a locked packet is abandoned.

Function
REQ-015 SHALL implement states IDLE, LOAD, HOLD, WAIT, GAP.
REQ-016 IDLE: if any req_valid=1, select the first valid index searching from rr_ptr+1 modulo NREQ, register grant, set rr_ptr to the winner, and go to LOAD next clock.
REQ-017 LOAD: if req_valid[g]=1 and tx_busy=0, assert tx_start=1, tx_data=req_data[g], and req_ready[g]=1 in the same clock, latch req_last[g], clear the stall counter, and go to HOLD.
REQ-018 LOAD: if req_valid[g]=0, keep grant (packet lock) and increment the stall counter; at stall count TIMEOUT, pulse timeout_err and go to GAP.
REQ-019 HOLD: lasts exactly one clock (covers the transmitter busy latency), then go to WAIT; tx_busy is ignored in HOLD.
REQ-020 WAIT: when tx_busy=0, go to GAP if the latched last=1, else go to LOAD.
REQ-021 GAP: clear grant on entry, count GAP_CYCLES clocks, then go to IDLE; with GAP_CYCLES=0, go from WAIT directly to IDLE.
REQ-022 Requests arriving during a packet or GAP SHALL not preempt; they are arbitrated only in IDLE.
REQ-023 Outside LOAD-accept, tx_start=0, req_ready=0, and tx_data=last value.
REQ-024 grant SHALL be one-hot or zero at all times; req_ready SHALL only ever pulse on the granted bit.
REQ-025 Single-byte packet (last=1 on first byte) SHALL follow IDLE->LOAD->HOLD->WAIT->GAP.
REQ-026 Byte throughput SHALL be one byte per transmitter frame plus 2 clocks maximum (LOAD + HOLD).
REQ-027 Counters SHALL saturate, never wrap: gap counter width is clog2(GAP_CYCLES+1), stall counter width is clog2(TIMEOUT+1).

Reset
REQ-028 reset=1 at any clock SHALL force IDLE, grant=0, rr_ptr=NREQ-1 (so requester 0 wins first), tx_start=0, req_ready=0, tx_data=0, timeout_err=0, and counters=0.
REQ-029 Reset mid-frame SHALL not wait for tx_busy; after reset release, a new tx_start is issued only when tx_busy=0.

Structure
REQ-030 Shared package uart_arb_pkg SHALL hold the state enum, default parameter constants, and a clog2 function.
REQ-031 The round-robin picker SHALL be a sub-module rr_picker (inputs: request vector and pointer; output: one-hot winner plus any flag), which is purely combinational.
REQ-032 The transmitter SHALL be instantiated outside this block; the arbiter connects only through tx_start/tx_data/tx_busy.

Verification
REQ-033 Single requester, valid[0] with bytes 0x41,0x42 (last on 0x42) -> two tx_start pulses with tx_data 0x41 then 0x42, each exactly 2 clocks after the prior tx_busy fall, then 16 gap clocks before the next grant.
REQ-034 Requesters 0 and 2 both valid from reset with 1-byte packets -> grant order 0, 2, 0, 2; no other req_ready bit ever pulses.
REQ-035 Requester 1 locked mid-packet and valid[1] dropped for 20 clocks while valid[3]=1 -> no grant change, and the packet resumes on requester 1 when valid[1] returns.
REQ-036 TIMEOUT=8 with valid dropped after the first non-last byte -> timeout_err pulses on stall clock 8, grant clears, and the next arbitration follows.
REQ-037 Reset asserted while tx_busy=1 mid-packet -> next clock all outputs are zero; the first tx_start after release waits for tx_busy=0.
REQ-038 GAP_CYCLES=0 build with back-to-back 1-byte packets from requesters 0 and 1 -> grants alternate with no idle clocks beyond WAIT->IDLE->LOAD.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type, defaults and width helpers for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_WAIT,
    ST_GAP
  } state_t;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_TIMEOUT    = 65535;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of a counter that must hold 0..max_count, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (clog2(max_count + 1) < 1) ? 1 : clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin picker searching from ptr+1
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]        req_i,
  input  logic [clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [clog2(NREQ)-1:0] idx_o,
  output logic                   any_o
);

  localparam int PW = clog2(NREQ);

  logic [PW-1:0] pos;

  // First asserted request after the pointer wins; the pointer itself is checked last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = PW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter in front of one shared UART transmitter
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_busy_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              timeout_err_o
);

  localparam int PW = clog2(NREQ);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam int SW = cnt_width(TIMEOUT);

  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_MAX    = GW'(GAP_CYCLES);
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] STALL_MAX  = SW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            last_q, last_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic            cur_valid;
  logic            cur_last;
  logic [7:0]      cur_data;
  logic            end_pkt;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Route the granted requester's byte lane, valid and last to the FSM.
  always_comb begin
    cur_data  = 8'h00;
    cur_valid = req_valid_i[gidx_q];
    cur_last  = req_last_i[gidx_q];
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == PW'(i)) cur_data = req_data_i[8*i +: 8];
    end
  end

  // State and datapath registers; reset drops any frame in flight without waiting on tx_busy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= PW'(NREQ - 1);
      last_q    <= 1'b0;
      stall_q   <= '0;
      gap_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      last_q    <= last_d;
      stall_q   <= stall_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Next-state and output decode; the grant is held for the whole packet and cleared when it ends.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    last_d        = last_q;
    stall_d       = stall_q;
    gap_d         = gap_q;
    tx_data_d     = tx_data_q;
    tx_start_o    = 1'b0;
    req_ready_o   = '0;
    timeout_err_o = 1'b0;
    end_pkt       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_gnt;
          gidx_d   = pick_idx;
          rr_ptr_d = pick_idx;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cur_valid) begin
          if (!tx_busy_i) begin
            tx_start_o  = 1'b1;
            req_ready_o = grant_q;
            tx_data_d   = cur_data;
            last_d      = cur_last;
            stall_d     = '0;
            state_d     = ST_HOLD;
          end
        end else if (stall_q == STALL_LAST) begin
          timeout_err_o = 1'b1;
          stall_d       = '0;
          end_pkt       = 1'b1;
        end else begin
          stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + SW'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tx_busy_i) begin
          if (last_q) end_pkt = 1'b1;
          else        state_d = ST_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_pkt) begin
      grant_d = '0;
      gap_d   = '0;
      state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
    end

    tx_data_o = tx_start_o ? cur_data : tx_data_q;
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        force_busy;
  logic        sel;
  logic        mon_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;

  logic [3:0] req_ready_a, grant_a, req_ready_b, grant_b;
  logic       tx_start_a, tx_busy_a, timeout_a, tx_start_b, tx_busy_b, timeout_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic [2:0] cnt_a = '0;
  logic [2:0] cnt_b = '0;

  // A: default gap and timeout. B: no gap, timeout after 8 stall clocks.
  uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(16), .TIMEOUT(65535)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(req_ready_a), .tx_start_o(tx_start_a),
    .tx_data_o(tx_data_a), .tx_busy_i(tx_busy_a), .grant_o(grant_a), .timeout_err_o(timeout_a)
  );

  uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0), .TIMEOUT(8)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(req_ready_b), .tx_start_o(tx_start_b),
    .tx_data_o(tx_data_b), .tx_busy_i(tx_busy_b), .grant_o(grant_b), .timeout_err_o(timeout_b)
  );

  // Transmitter stand-ins: busy for 4 clocks starting the clock after an accepted start.
  always @(posedge clk) begin
    if (tx_start_a && !tx_busy_a) cnt_a <= 3'd4;
    else if (cnt_a != 3'd0)       cnt_a <= cnt_a - 3'd1;
    if (tx_start_b && !tx_busy_b) cnt_b <= 3'd4;
    else if (cnt_b != 3'd0)       cnt_b <= cnt_b - 3'd1;
  end
  assign tx_busy_a = (cnt_a != 3'd0) || force_busy;
  assign tx_busy_b = (cnt_b != 3'd0) || force_busy;

  logic [3:0] obs_grant, obs_ready;
  logic       obs_tx_start, obs_timeout;
  logic [7:0] obs_tx_data;
  assign obs_grant    = sel ? grant_b     : grant_a;
  assign obs_ready    = sel ? req_ready_b : req_ready_a;
  assign obs_tx_start = sel ? tx_start_b  : tx_start_a;
  assign obs_timeout  = sel ? timeout_b   : timeout_a;
  assign obs_tx_data  = sel ? tx_data_b   : tx_data_a;

  int checks = 0;
  int errors = 0;
  int bad_ready = 0;
  int bad_grant = 0;
  int rdy_cnt[4] = '{0, 0, 0, 0};

  // Continuous legality of grant and ready on both instances, plus per-bit ready pulse counts.
  always @(negedge clk) begin
    if (mon_en) begin
      if (((req_ready_a & ~grant_a) != 4'd0) || ((req_ready_b & ~grant_b) != 4'd0)) bad_ready++;
      if (((grant_a & (grant_a - 4'd1)) != 4'd0) || ((grant_b & (grant_b - 4'd1)) != 4'd0)) bad_grant++;
      for (int i = 0; i < 4; i++) if (obs_ready[i]) rdy_cnt[i]++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    req_valid[i]      = 1'b1;
    req_data[8*i +: 8] = d;
    req_last[i]       = l;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    force_busy = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    repeat (6) step();
    reset = 1'b0;
  endtask

  task automatic wait_start(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!obs_tx_start && n < maxc);
  endtask

  int n;
  int bad;
  int rdy_base[4];
  logic [3:0] exp_g;

  initial begin
    sel    = 1'b0;
    mon_en = 1'b0;
    do_reset();
    mon_en = 1'b1;

    chk("rst_grant", obs_grant, 0);
    chk("rst_tx_start", obs_tx_start, 0);
    chk("rst_ready", obs_ready, 0);
    chk("rst_tx_data", obs_tx_data, 0);
    chk("rst_timeout", obs_timeout, 0);

    // Two-byte packet from requester 0, then 16 gap clocks before requester 1.
    set_req(0, 8'h41, 1'b0);
    wait_start(10, n);
    chk("p2_first_lat", n, 1);
    chk("p2_first_grant", obs_grant, 4'b0001);
    chk("p2_first_data", obs_tx_data, 8'h41);
    chk("p2_first_ready", obs_ready, 4'b0001);
    step();
    set_req(0, 8'h42, 1'b1);
    wait_start(20, n);
    chk("p2_byte_period", n, 5);
    chk("p2_second_data", obs_tx_data, 8'h42);
    chk("p2_second_ready", obs_ready, 4'b0001);
    step();
    req_valid[0] = 1'b0;
    set_req(1, 8'h55, 1'b1);
    n = 0;
    do begin step(); n++; end while (obs_grant != 4'd0 && n < 40);
    chk("p2_gap_entry", n, 5);
    n = 0;
    do begin step(); n++; end while (obs_grant == 4'd0 && n < 40);
    chk("p2_gap_len", n, 17);
    chk("p2_next_grant", obs_grant, 4'b0010);
    chk("p2_next_start", obs_tx_start, 1);
    chk("p2_next_data", obs_tx_data, 8'h55);

    // Requesters 0 and 2 continuously offering 1-byte packets.
    do_reset();
    rdy_base = rdy_cnt;
    set_req(0, 8'hA0, 1'b1);
    set_req(2, 8'hA2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      wait_start(60, n);
      chk("rr_grant", obs_grant, exp_g);
      chk("rr_data", obs_tx_data, (k % 2 == 0) ? 8'hA0 : 8'hA2);
    end
    step();
    chk("rr_ready0", rdy_cnt[0] - rdy_base[0], 2);
    chk("rr_ready1", rdy_cnt[1] - rdy_base[1], 0);
    chk("rr_ready2", rdy_cnt[2] - rdy_base[2], 2);
    chk("rr_ready3", rdy_cnt[3] - rdy_base[3], 0);

    // Requester 1 stalls mid-packet while requester 3 waits.
    do_reset();
    set_req(1, 8'h11, 1'b0);
    wait_start(10, n);
    chk("lock_first_grant", obs_grant, 4'b0010);
    chk("lock_first_data", obs_tx_data, 8'h11);
    step();
    req_valid[1] = 1'b0;
    set_req(3, 8'h33, 1'b1);
    bad = 0;
    repeat (25) begin
      step();
      if (obs_grant != 4'b0010 || obs_tx_start) bad++;
    end
    chk("lock_hold", bad, 0);
    set_req(1, 8'h12, 1'b1);
    #1;
    chk("lock_resume_start", obs_tx_start, 1);
    chk("lock_resume_grant", obs_grant, 4'b0010);
    chk("lock_resume_data", obs_tx_data, 8'h12);
    step();
    req_valid[1] = 1'b0;
    n = 0;
    do begin step(); n++; end while (obs_grant != 4'b1000 && n < 60);
    chk("lock_next_lat", n, 22);
    chk("lock_next_grant", obs_grant, 4'b1000);

    // Timeout on instance B after the first non-last byte.
    sel = 1'b1;
    do_reset();
    set_req(0, 8'h61, 1'b0);
    wait_start(10, n);
    chk("to_first_lat", n, 1);
    step();
    req_valid[0] = 1'b0;
    set_req(2, 8'h62, 1'b1);
    n = 0;
    do begin step(); n++; end while (!obs_timeout && n < 40);
    chk("to_pulse_lat", n, 12);
    chk("to_pulse_grant", obs_grant, 4'b0001);
    step();
    chk("to_pulse_width", obs_timeout, 0);
    chk("to_grant_clear", obs_grant, 0);
    step();
    chk("to_next_grant", obs_grant, 4'b0100);
    chk("to_next_start", obs_tx_start, 1);
    chk("to_next_data", obs_tx_data, 8'h62);

    // Reset while the transmitter is busy mid-packet.
    sel = 1'b0;
    do_reset();
    set_req(0, 8'h71, 1'b0);
    wait_start(10, n);
    step();
    step();
    force_busy = 1'b1;
    reset      = 1'b1;
    step();
    chk("mid_rst_grant", obs_grant, 0);
    chk("mid_rst_tx_start", obs_tx_start, 0);
    chk("mid_rst_ready", obs_ready, 0);
    chk("mid_rst_tx_data", obs_tx_data, 0);
    chk("mid_rst_timeout", obs_timeout, 0);
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      step();
      if (obs_tx_start) bad++;
    end
    chk("mid_rst_no_start_busy", bad, 0);
    force_busy = 1'b0;
    #1;
    chk("mid_rst_start", obs_tx_start, 1);
    chk("mid_rst_data", obs_tx_data, 8'h71);
    chk("mid_rst_grant0", obs_grant, 4'b0001);

    // Back-to-back 1-byte packets on the gapless instance.
    sel = 1'b1;
    do_reset();
    set_req(0, 8'h80, 1'b1);
    set_req(1, 8'h81, 1'b1);
    wait_start(10, n);
    chk("nogap_first_lat", n, 1);
    chk("nogap_first_grant", obs_grant, 4'b0001);
    chk("nogap_first_data", obs_tx_data, 8'h80);
    for (int k = 1; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 4'b0010 : 4'b0001;
      wait_start(30, n);
      chk("nogap_period", n, 7);
      chk("nogap_grant", obs_grant, exp_g);
      chk("nogap_data", obs_tx_data, (k % 2 == 1) ? 8'h81 : 8'h80);
    end

    step();
    chk("ready_only_granted", bad_ready, 0);
    chk("grant_onehot0", bad_grant, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
